vga_frame_capture: RTL and testbench
====================================

// Module: vga_frame_capture
// PURPOSE
//  Receive-side counterpart of the VGA generator: samples VGA_HS/VGA_VS/RGB from the
//  timing generator (same clk domain), locks to frame timing, and writes one
//  CAP_W x CAP_H window of pixels into a frame-buffer write port. Used for on-chip
//  loopback checking of the 200x164 picture path and as a frame grabber.
// PARAMETERS
//  PIX_DIV   2    clk cycles per pixel (50 MHz clk -> 25 MHz pixel)
//  H_SYNC    96   hsync width, pixels;   H_BACK 48  back porch, pixels
//  H_TOTAL   800  pixels per line;       V_SYNC 2   vsync width, lines
//  V_BACK    33   back porch, lines;     V_TOTAL 525 lines per frame
//  CAP_X     0    window x offset in active area; CAP_Y 0 window y offset
//  CAP_W     200  window width, pixels;  CAP_H 164  window height, lines
//  ADDR_W    16   write-address width (must hold CAP_W*CAP_H-1)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       async reset, active high
//  vga_hs     in   1       hsync, active low
//  vga_vs     in   1       vsync, active low
//  vga_rgb    in   8       pixel data
//  cap_en     in   1       arm capture; sampled only at frame start
//  wr_en      out  1       one-cycle pixel write strobe
//  wr_addr    out  ADDR_W  linear address y*CAP_W+x
//  wr_data    out  8       captured pixel
//  frame_done out  1       one-cycle pulse after last window pixel written
//  locked     out  1       timing lock status
//  sync_err   out  1       one-cycle pulse on timing mismatch
// BEHAVIOUR
//  - Reset: all outputs 0; state SEARCH; all counters 0. Async assert, sync release.
//  - Inputs registered once; edges detected from registered vs previous value.
//  - HS falling edge: clk counter hclk<=0, line counter vcnt+=1. VS falling edge
//    (coincident with an HS fall): vcnt<=0. Pixel index hpix=hclk/PIX_DIV; sample
//    point is hclk%PIX_DIV==PIX_DIV-1.
//  - States: SEARCH -> MEASURE on VS fall. MEASURE: every HS fall checks
//    hclk+1==H_TOTAL*PIX_DIV; next VS fall checks vcnt+1==V_TOTAL. All ok -> LOCKED,
//    else sync_err pulse and restart MEASURE. LOCKED: same checks continuously;
//    any mismatch -> sync_err, locked<=0, SEARCH (in-progress capture aborted, no
//    frame_done). hclk/vcnt saturate at all-ones (missing sync => mismatch).
//  - cap_en sampled at VS fall while LOCKED (or on MEASURE->LOCKED); capture
//    window active for that whole frame only; deassert mid-frame has no effect.
//  - Window pixel: hpix-(H_SYNC+H_BACK)-CAP_X in [0,CAP_W) and
//    vcnt-(V_SYNC+V_BACK)-CAP_Y in [0,CAP_H). Address counter cleared at VS fall,
//    +1 per write; never wraps (exactly CAP_W*CAP_H writes per captured frame).
//  - Latency: wr_en/wr_data/wr_addr registered, valid 2 clk after vga_rgb present
//    on input at sample point. wr_addr/wr_data hold last value when wr_en=0.
//  - frame_done: 1 clk after final write (addr CAP_W*CAP_H-1), same frame.
//  - Simultaneous VS fall and last write of old frame: write completes, then clear.
// TESTING
//  1 Standard 800x525 timing, cap_en=1: locked rises at 2nd VS fall (1 frame);
//    next frame gives 32800 writes, addr 0..32799, frame_done once.
//  2 Gradient RGB = hpix[7:0] ^ vcnt[7:0]: wr_data at addr 0 = 144^35 (=0xB3),
//    addr 32799 matches pixel (343,198) value; all addresses compared.
//  3 One line shortened to 799 pixels while LOCKED: sync_err pulse at that HS fall,
//    locked=0, no frame_done; relock after 1 good frame.
//  4 cap_en=0 at VS fall, raised mid-frame: zero writes that frame; capture next.
//  5 rst asserted mid-window: all outputs 0 same cycle; after release, SEARCH,
//    locked=0 until one full good frame measured.
//  6 Override CAP_X=10,CAP_Y=5,CAP_W=4,CAP_H=2: 8 writes at pixels (154..157,40..41).

Source files
------------

// File: rtl/vga_frame_capture.sv
// Receive-side VGA frame grabber: locks to HS/VS timing from the generator and writes one
// CAP_W x CAP_H window of pixels per armed frame into a frame-buffer write port.
module vga_frame_capture #(
  parameter int unsigned PIX_DIV = 2,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned CAP_X   = 0,
  parameter int unsigned CAP_Y   = 0,
  parameter int unsigned CAP_W   = 200,
  parameter int unsigned CAP_H   = 164,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_hs,
  input  logic              vga_vs,
  input  logic [7:0]        vga_rgb,
  input  logic              cap_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int unsigned HC_W = $clog2(H_TOTAL * PIX_DIV) + 1;
  localparam int unsigned VC_W = $clog2(V_TOTAL) + 1;
  localparam int unsigned PH_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam int unsigned X_LO_I = H_SYNC + H_BACK + CAP_X;
  localparam int unsigned Y_LO_I = V_SYNC + V_BACK + CAP_Y;

  localparam logic [HC_W-1:0]   H_LAST    = HC_W'(H_TOTAL * PIX_DIV - 1);
  localparam logic [VC_W-1:0]   V_LAST    = VC_W'(V_TOTAL - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PIX_DIV - 1);
  localparam logic [HC_W-1:0]   X_LO      = HC_W'(X_LO_I);
  localparam logic [HC_W-1:0]   X_HI      = HC_W'(X_LO_I + CAP_W);
  localparam logic [VC_W-1:0]   Y_LO      = VC_W'(Y_LO_I);
  localparam logic [VC_W-1:0]   Y_HI      = VC_W'(Y_LO_I + CAP_H);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CAP_W * CAP_H - 1);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  state_e            state_q;
  logic              hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [7:0]        rgb_q, rgb_dly_q;
  logic [HC_W-1:0]   hclk_q, hpix_q;
  logic [PH_W-1:0]   phase_q;
  logic [VC_W-1:0]   vcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              cap_active_q, meas_bad_q, last_q;

  logic hs_fall, vs_fall, h_ok, v_ok, mismatch, sample, in_win, fire;

  assign hs_fall  = hs_prev_q & ~hs_q;
  assign vs_fall  = vs_prev_q & ~vs_q;
  assign h_ok     = (hclk_q == H_LAST);
  assign v_ok     = (vcnt_q == V_LAST);
  assign mismatch = (hs_fall & ~h_ok) | (vs_fall & ~v_ok);
  assign sample   = (phase_q == PH_LAST);
  assign in_win   = (hpix_q >= X_LO) && (hpix_q < X_HI) && (vcnt_q >= Y_LO) && (vcnt_q < Y_HI);
  assign fire     = cap_active_q & sample & in_win;

  // Edge detection costs two register stages, so pixel data is delayed twice to stay
  // aligned with hclk: while hclk == h, rgb_dly_q holds the input of line clock h.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
      rgb_dly_q <= '0;
      hclk_q    <= '0;
      hpix_q    <= '0;
      phase_q   <= '0;
      vcnt_q    <= '0;
    end else begin
      hs_q      <= vga_hs;
      hs_prev_q <= hs_q;
      vs_q      <= vga_vs;
      vs_prev_q <= vs_q;
      rgb_q     <= vga_rgb;
      rgb_dly_q <= rgb_q;
      if (hs_fall) begin
        hclk_q  <= '0;
        hpix_q  <= '0;
        phase_q <= '0;
      end else begin
        if (hclk_q != '1) hclk_q <= hclk_q + 1'b1;
        if (sample) begin
          phase_q <= '0;
          if (hpix_q != '1) hpix_q <= hpix_q + 1'b1;
        end else begin
          phase_q <= phase_q + 1'b1;
        end
      end
      if (vs_fall) begin
        vcnt_q <= '0;
      end else if (hs_fall && vcnt_q != '1) begin
        vcnt_q <= vcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StSearch;
      locked       <= 1'b0;
      sync_err     <= 1'b0;
      meas_bad_q   <= 1'b0;
      cap_active_q <= 1'b0;
      addr_q       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      last_q       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sync_err   <= 1'b0;
      wr_en      <= fire;
      last_q     <= fire && (addr_q == ADDR_LAST);
      frame_done <= last_q;
      if (fire) begin
        wr_addr <= addr_q;
        wr_data <= rgb_dly_q;
        addr_q  <= addr_q + 1'b1;
        // Disarm after the last pixel so the address can never wrap.
        if (addr_q == ADDR_LAST) cap_active_q <= 1'b0;
      end
      // A write coinciding with VS fall uses the old address; the clear wins afterwards.
      if (vs_fall) addr_q <= '0;

      unique case (state_q)
        StSearch: begin
          if (vs_fall) begin
            state_q    <= StMeasure;
            meas_bad_q <= 1'b0;
          end
        end
        StMeasure: begin
          if (mismatch) sync_err <= 1'b1;
          if (vs_fall) begin
            meas_bad_q <= 1'b0;
            if (!mismatch && !meas_bad_q) begin
              state_q      <= StLocked;
              locked       <= 1'b1;
              cap_active_q <= cap_en;
            end
          end else if (mismatch) begin
            meas_bad_q <= 1'b1;
          end
        end
        StLocked: begin
          if (mismatch) begin
            sync_err     <= 1'b1;
            locked       <= 1'b0;
            state_q      <= StSearch;
            cap_active_q <= 1'b0;
          end else if (vs_fall) begin
            cap_active_q <= cap_en;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a shrunken VGA timing (20x16 total, 6x4 window) so that
// a dozen frames run quickly; expected writes go into a scoreboard queue.
module tb_vga_frame_capture;

  localparam int PD    = 2;
  localparam int HS    = 4;
  localparam int HB    = 2;
  localparam int HT    = 20;
  localparam int VS    = 2;
  localparam int VB    = 3;
  localparam int VT    = 16;
  localparam int CX    = 1;
  localparam int CY    = 1;
  localparam int CW    = 6;
  localparam int CH    = 4;
  localparam int AW    = 8;
  localparam int LINE  = HT * PD;
  localparam int FRAME = LINE * VT;
  localparam int NPIX  = CW * CH;

  // Window covers pixels x=7..12, lines y=6..9; generator pixel value is x ^ y.
  logic [7:0] exp_pix [NPIX] = '{
    8'd1,  8'd14, 8'd15, 8'd12, 8'd13, 8'd10,
    8'd0,  8'd15, 8'd14, 8'd13, 8'd12, 8'd11,
    8'd15, 8'd0,  8'd1,  8'd2,  8'd3,  8'd4,
    8'd14, 8'd1,  8'd0,  8'd3,  8'd2,  8'd5
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vga_hs, vga_vs, cap_en;
  logic [7:0]    vga_rgb;
  logic          wr_en, frame_done, locked, sync_err;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  int checks = 0;
  int errors = 0;
  int exp_addr_q [$];
  int exp_data_q [$];
  int fd_cnt = 0;
  int se_cycles = 0;

  int gh, gv, cur_len, frame_cnt;
  bit short_req = 1'b0;

  always #5 clk = ~clk;

  vga_frame_capture #(
    .PIX_DIV(PD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .CAP_X(CX), .CAP_Y(CY), .CAP_W(CW), .CAP_H(CH), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_rgb(vga_rgb),
    .cap_en(cap_en),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .locked(locked),
    .sync_err(sync_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame(input int k);
    int n = 0;
    while (frame_cnt < k && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (frame_cnt < k) check("wait_frame_timeout", 32'(frame_cnt), 32'(k));
  endtask

  task automatic wait_line(input int l);
    int n = 0;
    while (gv != l && n < FRAME) begin
      @(negedge clk);
      n++;
    end
    if (gv != l) check("wait_line_timeout", 32'(gv), 32'(l));
  endtask

  task automatic push_frame(input int n);
    for (int a = 0; a < n; a++) begin
      exp_addr_q.push_back(a);
      exp_data_q.push_back(int'(exp_pix[a]));
    end
  endtask

  // Timing generator: line starts with HS low, frame starts with VS low on line 0.
  initial begin
    gh = 0; gv = 0; frame_cnt = 0; cur_len = LINE;
    vga_hs = 1'b1; vga_vs = 1'b1; vga_rgb = 8'd0;
    forever begin
      @(negedge clk);
      vga_hs  = (gh >= HS * PD);
      vga_vs  = (gv >= VS);
      vga_rgb = 8'((gh / PD) ^ gv);
      gh++;
      if (gh >= cur_len) begin
        gh = 0;
        if (short_req) begin
          cur_len   = LINE - PD;
          short_req = 1'b0;
        end else begin
          cur_len = LINE;
        end
        if (gv == VT - 1) begin
          gv = 0;
          frame_cnt++;
        end else begin
          gv++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every write strobe.
  initial begin
    logic          prev_wr;
    logic [AW-1:0] prev_addr;
    int            ea, ed;
    prev_wr = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_write_addr", 32'(wr_addr), 32'hFFFF_FFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          ed = exp_data_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(ea));
          check("wr_data", 32'(wr_data), 32'(ed));
        end
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        check("frame_done_after_write", 32'(prev_wr), 32'd1);
        check("frame_done_last_addr", 32'(prev_addr), 32'(NPIX - 1));
      end
      if (sync_err === 1'b1) se_cycles++;
      prev_wr   = wr_en;
      prev_addr = wr_addr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks,
             errors);
    $fatal(1, "watchdog");
  end

  initial begin
    cap_en = 1'b1;
    wait_cycles(3);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    wait_cycles(7);
    rst = 1'b0;

    // First VS fall only starts measurement; lock comes with the second.
    wait_frame(1);
    wait_cycles(100);
    check("locked_while_measuring", 32'(locked), 32'd0);
    wait_frame(2);
    check("locked_before_2nd_vs", 32'(locked), 32'd0);
    wait_cycles(5);
    check("locked_after_2nd_vs", 32'(locked), 32'd1);
    push_frame(NPIX);

    // Frame 3 captured; dropping cap_en mid-window does not cut it short.
    wait_frame(3);
    wait_cycles(5);
    check("frame_done_count_f2", 32'(fd_cnt), 32'd1);
    check("writes_left_f2", 32'(exp_addr_q.size()), 32'd0);
    check("wr_addr_hold", 32'(wr_addr), 32'(NPIX - 1));
    check("wr_data_hold", 32'(wr_data), 32'd5);
    push_frame(NPIX);
    wait_line(7);
    cap_en = 1'b0;

    // Frame 4 not armed; raising cap_en mid-frame arms frame 5 only.
    wait_frame(4);
    wait_cycles(5);
    check("frame_done_count_f3", 32'(fd_cnt), 32'd2);
    check("writes_left_f3", 32'(exp_addr_q.size()), 32'd0);
    wait_line(3);
    cap_en = 1'b1;
    wait_frame(5);
    wait_cycles(5);
    check("frame_done_count_f4", 32'(fd_cnt), 32'd2);
    push_frame(NPIX);

    // Frame 6: line 7 one pixel short aborts the capture after two window lines.
    wait_frame(6);
    wait_cycles(5);
    check("frame_done_count_f5", 32'(fd_cnt), 32'd3);
    check("writes_left_f5", 32'(exp_addr_q.size()), 32'd0);
    check("no_sync_err_yet", 32'(se_cycles), 32'd0);
    push_frame(2 * CW);
    wait_line(6);
    short_req = 1'b1;
    wait_line(9);
    check("sync_err_pulse", 32'(se_cycles), 32'd1);
    check("unlocked_after_err", 32'(locked), 32'd0);
    check("writes_left_f6", 32'(exp_addr_q.size()), 32'd0);
    wait_frame(7);
    wait_cycles(5);
    check("no_frame_done_f6", 32'(fd_cnt), 32'd3);
    check("remeasure_locked", 32'(locked), 32'd0);
    wait_frame(8);
    wait_cycles(5);
    check("relocked", 32'(locked), 32'd1);
    push_frame(NPIX);

    // Frame 9: reset in the middle of the window.
    wait_frame(9);
    wait_cycles(5);
    check("frame_done_count_f8", 32'(fd_cnt), 32'd4);
    check("writes_left_f8", 32'(exp_addr_q.size()), 32'd0);
    push_frame(CW);
    wait_line(7);
    rst = 1'b1;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_addr", 32'(wr_addr), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_sync_err", 32'(sync_err), 32'd0);
    check("writes_left_f9", 32'(exp_addr_q.size()), 32'd0);
    wait_cycles(4);
    rst = 1'b0;
    wait_frame(10);
    wait_cycles(100);
    check("post_rst_measuring", 32'(locked), 32'd0);
    wait_frame(11);
    wait_cycles(5);
    check("post_rst_locked", 32'(locked), 32'd1);
    push_frame(NPIX);

    wait_frame(12);
    wait_cycles(5);
    check("frame_done_total", 32'(fd_cnt), 32'd5);
    check("writes_left_end", 32'(exp_addr_q.size()), 32'd0);
    check("sync_err_total", 32'(se_cycles), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
